nmos_phase_ctrl: RTL and testbench
==================================

Name: nmos_phase_ctrl

Overview:
- Two-phase, non-overlapping gate-clock sequencer for the NMOS simulation library.
- Drives the G inputs of pass-transistor cells: phi1 feeds one latch bank, phi2 the other, with a programmable dead time between phases.
- Sits beside the global clock generator and is clocked by main_clk.
- Supports free-running and single-step operation so benches can advance the modelled circuit one full phi1/phi2 cycle at a time.

Parameters:
- CNT_W, 8, width of the phase-length and gap-length config fields and of the internal down-counter.
- CYC_W, 16, width of the completed-cycle counter.

Ports:
- main_clk  in  1  simulation master clock (same net as the global main_clk).
- main_rst_n  in  1  asynchronous active-low reset.
- run  in  1  level; while high, cycles repeat back-to-back.
- step  in  1  one-clock pulse; requests exactly one cycle from IDLE.
- phi1_len  in  CNT_W  phi1 high time in main_clk cycles.
- phi2_len  in  CNT_W  phi2 high time in main_clk cycles.
- gap_len  in  CNT_W  dead time after each phase.
- phi1  out  1  gate enable, phase 1.
- phi2  out  1  gate enable, phase 2.
- gap  out  1  high during dead-time states.
- busy  out  1  high whenever state != IDLE.
- cycle_done  out  1  one-clock pulse per completed cycle.
- cycle_cnt  out  CYC_W  count of completed cycles, wraps.

Behaviour:
- Clock and reset: single clock main_clk, rising edge. main_rst_n is asynchronous and active-low.
- Reset, asynchronous on main_rst_n low:
  - state goes to IDLE.
  - phi1, phi2, gap, busy and cycle_done all go to 0 immediately.
  - cycle_cnt goes to 0.
  - Counter and shadow config registers are cleared.
  - A reset mid-phase truncates that phase. This is the only case in which a phase is truncated.
- All outputs are registered and decoded from the next state, so they change only on main_clk edges.
- States: IDLE, PH1, GAP1, PH2, GAP2.
- Config shadowing: phi1_len, phi2_len and gap_len are captured into shadow registers on every transition into PH1. Changing the inputs mid-cycle has no effect until the next cycle.
- Length rules:
  - A phase length of 0 is treated as 1; a gate pulse is never shorter than one clock.
  - gap_len = 0 skips GAP1 and GAP2: PH1 goes directly to PH2, and PH2 directly to cycle end.
  - Each state lasts exactly its shadowed length. The counter loads len-1 on entry and the state exits when the counter is 0.
- IDLE to PH1:
  - Taken at edge k if run=1 or step=1 is sampled at edge k.
  - phi1 is high from edge k to edge k+phi1_len: one clock of latency from request to gate.
  - step asserted while busy=1 is ignored (not queued).
- Sequence: PH1 -> GAP1 -> PH2 -> GAP2 -> end of cycle.
- End of cycle (edge after the last GAP2 cycle, or the last PH2 cycle when gap is 0):
  - cycle_done=1 for that one clock.
  - cycle_cnt increments, wrapping 2^CYC_W-1 -> 0.
  - If run=1 at that edge: go back-to-back to PH1 with a re-shadowed config.
  - Otherwise go to IDLE.
- Dropping run mid-cycle completes the current cycle fully, then the block idles.
- run and step high simultaneously in IDLE start one cycle. Continuation is then governed by run.
- Invariant: phi1 & phi2 is never 1. With gap_len=0 the phases are adjacent but never overlapping.
- gap = 1 exactly in GAP1 and GAP2.
- busy = 1 from the first phi1 clock through the last cycle of GAP2 (or PH2 when gap is 0). busy is 0 in the cycle_done clock only if the block returns to IDLE.

Test Plan:
- Single step:
  - Setup: reset, then phi1_len=3, gap_len=1, phi2_len=2, step pulse at edge 0.
  - phi1 high over edges 1-3, gap over edge 4, phi2 over edges 5-6, gap over edge 7.
  - cycle_done at edge 8, cycle_cnt=1, busy=0 from edge 8.
- Free run:
  - Setup: run=1, lengths 2/0/2 (phi1/gap/phi2).
  - Pattern is phi1,phi1,phi2,phi2 repeating with no gap cycles and no overlap.
  - cycle_done every 4 clocks; cycle_cnt counts 1,2,3.
- Zero lengths: phi1_len=0, phi2_len=0, gap_len=0 with step -> one clock of phi1, then one clock of phi2, then cycle_done; phi1&phi2 never both 1.
- Mid-cycle changes:
  - Drop run and change phi1_len 4 -> 1 during PH2.
  - The current cycle finishes with the old lengths.
  - The block goes to IDLE; the next step uses phi1_len=1.
- Async reset: assert main_rst_n=0 mid-PH1 (between clock edges) -> phi1=0 and cycle_cnt=0 immediately; after release, no activity until run or step.
- Wrap: with CYC_W=4, run 17 cycles -> cycle_cnt wraps 15 -> 0 -> 1; step pulses during busy produce no extra cycles.

Source files
------------

// File: rtl/nmos_phase_if.sv
// Bus between a bench (or global clock generator) and the two-phase
// gate-clock sequencer: run/step requests and phase/gap lengths in,
// gate enables and cycle status out.
interface nmos_phase_if #(
  parameter int CNT_W = 8,
  parameter int CYC_W = 16
);
  logic             run;
  logic             step;
  logic [CNT_W-1:0] phi1_len;
  logic [CNT_W-1:0] phi2_len;
  logic [CNT_W-1:0] gap_len;
  logic             phi1;
  logic             phi2;
  logic             gap;
  logic             busy;
  logic             cycle_done;
  logic [CYC_W-1:0] cycle_cnt;

  modport master (
    output run, step, phi1_len, phi2_len, gap_len,
    input  phi1, phi2, gap, busy, cycle_done, cycle_cnt
  );

  modport slave (
    input  run, step, phi1_len, phi2_len, gap_len,
    output phi1, phi2, gap, busy, cycle_done, cycle_cnt
  );
endinterface

// File: rtl/nmos_phase_ctrl.sv
// Two-phase non-overlapping gate-clock sequencer.
//
//   state | meaning
//   ------+------------------------------------------------------
//   IDLE  | no cycle in progress, waiting for run or step
//   PH1   | phi1 gate enable high for phi1_len clocks (min 1)
//   GAP1  | dead time after phi1, gap_len clocks (skipped if 0)
//   PH2   | phi2 gate enable high for phi2_len clocks (min 1)
//   GAP2  | dead time after phi2, gap_len clocks (skipped if 0)
//
// Outputs are registered from the next state so they only move on
// main_clk edges. The end of a cycle is the edge that leaves the last
// PH2/GAP2 clock; cycle_done is high for the clock that follows it,
// which is either the first PH1 clock of the next cycle or an IDLE clock.
module nmos_phase_ctrl #(
  parameter int CNT_W = 8,
  parameter int CYC_W = 16
) (
  input  logic         main_clk,
  input  logic         main_rst_n,
  nmos_phase_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PH1  = 3'd1,
    GAP1 = 3'd2,
    PH2  = 3'd3,
    GAP2 = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CYC_W-1:0] CYC_ONE = {{(CYC_W-1){1'b0}}, 1'b1};

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             cnt_zero;
  logic             load_cfg;
  logic             end_cycle;

  // phi1 length is consumed entirely by the counter load on PH1 entry,
  // so only the lengths used later in the cycle need shadow copies.
  logic [CNT_W-1:0] phi2_sh;
  logic [CNT_W-1:0] gap_sh;
  logic             gap_zero;

  logic             phi1_q;
  logic             phi2_q;
  logic             gap_q;
  logic             busy_q;
  logic             done_q;
  logic [CYC_W-1:0] cyc_q;

  // Counter reload value: a length of 0 behaves as 1 for phases, and
  // the state exits when the counter has run down to 0.
  function automatic logic [CNT_W-1:0] len_m1(input logic [CNT_W-1:0] len);
    return (len == '0) ? '0 : (len - CNT_ONE);
  endfunction

  assign cnt_zero = (cnt == '0);
  assign gap_zero = (gap_sh == '0);

  // State register and down-counter.
  always_ff @(posedge main_clk or negedge main_rst_n) begin
    if (!main_rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state and counter-reload decode.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    load_cfg  = 1'b0;
    end_cycle = 1'b0;
    case (state)
      IDLE: begin
        if (bus.run || bus.step) begin
          state_nxt = PH1;
          cnt_nxt   = len_m1(bus.phi1_len);
          load_cfg  = 1'b1;
        end
      end
      PH1: begin
        if (!cnt_zero) begin
          cnt_nxt = cnt - CNT_ONE;
        end else if (!gap_zero) begin
          state_nxt = GAP1;
          cnt_nxt   = len_m1(gap_sh);
        end else begin
          state_nxt = PH2;
          cnt_nxt   = len_m1(phi2_sh);
        end
      end
      GAP1: begin
        if (!cnt_zero) begin
          cnt_nxt = cnt - CNT_ONE;
        end else begin
          state_nxt = PH2;
          cnt_nxt   = len_m1(phi2_sh);
        end
      end
      PH2: begin
        if (!cnt_zero) begin
          cnt_nxt = cnt - CNT_ONE;
        end else if (!gap_zero) begin
          state_nxt = GAP2;
          cnt_nxt   = len_m1(gap_sh);
        end else begin
          end_cycle = 1'b1;
        end
      end
      GAP2: begin
        if (!cnt_zero) begin
          cnt_nxt = cnt - CNT_ONE;
        end else begin
          end_cycle = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase

    // step is only looked at in IDLE, so a step during a cycle is dropped.
    if (end_cycle) begin
      if (bus.run) begin
        state_nxt = PH1;
        cnt_nxt   = len_m1(bus.phi1_len);
        load_cfg  = 1'b1;
      end else begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    end
  end

  // Capture the later-phase lengths at the start of every cycle.
  always_ff @(posedge main_clk or negedge main_rst_n) begin
    if (!main_rst_n) begin
      phi2_sh <= '0;
      gap_sh  <= '0;
    end else if (load_cfg) begin
      phi2_sh <= bus.phi2_len;
      gap_sh  <= bus.gap_len;
    end
  end

  // Registered outputs decoded from the next state.
  always_ff @(posedge main_clk or negedge main_rst_n) begin
    if (!main_rst_n) begin
      phi1_q <= 1'b0;
      phi2_q <= 1'b0;
      gap_q  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      phi1_q <= (state_nxt == PH1);
      phi2_q <= (state_nxt == PH2);
      gap_q  <= (state_nxt == GAP1) || (state_nxt == GAP2);
      busy_q <= (state_nxt != IDLE);
      done_q <= end_cycle;
    end
  end

  // Completed-cycle counter, wraps naturally at 2^CYC_W.
  always_ff @(posedge main_clk or negedge main_rst_n) begin
    if (!main_rst_n) begin
      cyc_q <= '0;
    end else if (end_cycle) begin
      cyc_q <= cyc_q + CYC_ONE;
    end
  end

  assign bus.phi1       = phi1_q;
  assign bus.phi2       = phi2_q;
  assign bus.gap        = gap_q;
  assign bus.busy       = busy_q;
  assign bus.cycle_done = done_q;
  assign bus.cycle_cnt  = cyc_q;

endmodule

// File: tb/tb_nmos_phase_ctrl.sv
// Directed bench for nmos_phase_ctrl. Inputs are driven and outputs are
// sampled on the falling edge of main_clk. Output vectors are packed as
// {phi1, phi2, gap, busy, cycle_done}; the cycle counter is 4 bits wide
// here so that wrap-around is reachable in a short run.
module tb_nmos_phase_ctrl;

  logic main_clk = 1'b0;
  logic main_rst_n;

  always #5 main_clk = ~main_clk;

  nmos_phase_if #(.CNT_W(8), .CYC_W(4)) bus ();

  nmos_phase_ctrl #(.CNT_W(8), .CYC_W(4)) dut (
    .main_clk   (main_clk),
    .main_rst_n (main_rst_n),
    .bus        (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // single step 3/1/2
  localparam logic [4:0] SS_O [9] = '{5'b10010, 5'b10010, 5'b10010, 5'b00110,
                                      5'b01010, 5'b01010, 5'b00110, 5'b00001,
                                      5'b00000};
  localparam logic [3:0] SS_C [9] = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0,
                                      4'd1, 4'd1};

  task automatic chk(input string tag, input logic [4:0] exp_o, input logic [3:0] exp_c);
    logic [8:0] obs;
    logic [8:0] expv;
    obs  = {bus.phi1, bus.phi2, bus.gap, bus.busy, bus.cycle_done, bus.cycle_cnt};
    expv = {exp_o, exp_c};
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, expv);
    end
  endtask

  initial begin
    logic [4:0] eo;
    logic [3:0] ec;
    logic       b;
    int         k;

    bus.run      = 1'b0;
    bus.step     = 1'b0;
    bus.phi1_len = 8'd0;
    bus.phi2_len = 8'd0;
    bus.gap_len  = 8'd0;
    main_rst_n   = 1'b1;
    #2 main_rst_n = 1'b0;
    #1 chk("reset", 5'b00000, 4'd0);
    @(negedge main_clk);
    main_rst_n = 1'b1;
    @(negedge main_clk);
    chk("idle_after_reset", 5'b00000, 4'd0);

    // Single step, phi1=3 gap=1 phi2=2
    bus.phi1_len = 8'd3;
    bus.gap_len  = 8'd1;
    bus.phi2_len = 8'd2;
    bus.step     = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(negedge main_clk);
      bus.step = 1'b0;
      chk($sformatf("single_step[%0d]", i), SS_O[i], SS_C[i]);
    end

    // Free run 2/0/2 after a fresh reset, run dropped near the end of cycle 3
    main_rst_n = 1'b0;
    @(negedge main_clk);
    main_rst_n   = 1'b1;
    bus.phi1_len = 8'd2;
    bus.gap_len  = 8'd0;
    bus.phi2_len = 8'd2;
    bus.run      = 1'b1;
    for (int i = 0; i <= 12; i++) begin
      @(negedge main_clk);
      if (i == 12) begin
        eo = 5'b00001;
      end else begin
        eo = {((i % 4) < 2), ((i % 4) >= 2), 1'b0, 1'b1, ((i % 4) == 0) && (i > 0)};
      end
      ec = 4'(i / 4);
      chk($sformatf("free_run[%0d]", i), eo, ec);
      if (i == 11) bus.run = 1'b0;
    end

    // Zero lengths with a single step
    bus.phi1_len = 8'd0;
    bus.phi2_len = 8'd0;
    bus.gap_len  = 8'd0;
    bus.step     = 1'b1;
    @(negedge main_clk);
    bus.step = 1'b0;
    chk("zero_len_ph1", 5'b10010, 4'd3);
    @(negedge main_clk);
    chk("zero_len_ph2", 5'b01010, 4'd3);
    @(negedge main_clk);
    chk("zero_len_done", 5'b00001, 4'd4);
    @(negedge main_clk);
    chk("zero_len_idle", 5'b00000, 4'd4);

    // Mid-cycle change: run dropped and lengths changed during PH2
    bus.phi1_len = 8'd4;
    bus.phi2_len = 8'd2;
    bus.gap_len  = 8'd0;
    bus.run      = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge main_clk);
      if (i < 4)       eo = 5'b10010;
      else if (i < 6)  eo = 5'b01010;
      else if (i == 6) eo = 5'b00001;
      else             eo = 5'b00000;
      ec = (i >= 6) ? 4'd5 : 4'd4;
      chk($sformatf("mid_change[%0d]", i), eo, ec);
      if (i == 4) begin
        bus.run      = 1'b0;
        bus.phi1_len = 8'd1;
        bus.phi2_len = 8'd1;
      end
    end
    bus.step = 1'b1;
    @(negedge main_clk);
    bus.step = 1'b0;
    chk("new_len_ph1", 5'b10010, 4'd5);
    @(negedge main_clk);
    chk("new_len_ph2", 5'b01010, 4'd5);
    @(negedge main_clk);
    chk("new_len_done", 5'b00001, 4'd6);
    @(negedge main_clk);
    chk("new_len_idle", 5'b00000, 4'd6);

    // Asynchronous reset in the middle of PH1
    bus.phi1_len = 8'd3;
    bus.gap_len  = 8'd1;
    bus.phi2_len = 8'd1;
    bus.step     = 1'b1;
    @(negedge main_clk);
    bus.step = 1'b0;
    chk("pre_reset_ph1_a", 5'b10010, 4'd6);
    @(negedge main_clk);
    chk("pre_reset_ph1_b", 5'b10010, 4'd6);
    #2 main_rst_n = 1'b0;
    #1 chk("async_reset", 5'b00000, 4'd0);
    @(negedge main_clk);
    main_rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge main_clk);
      chk($sformatf("post_reset_idle[%0d]", i), 5'b00000, 4'd0);
    end

    // Wrap: 17 cycles of 1/0/1, with step pulses while busy
    bus.phi1_len = 8'd1;
    bus.phi2_len = 8'd1;
    bus.gap_len  = 8'd0;
    bus.run      = 1'b1;
    for (int i = 0; i <= 36; i++) begin
      @(negedge main_clk);
      b  = (i <= 33);
      k  = (i > 34) ? 34 : i;
      eo = {b && (i % 2 == 0), b && (i % 2 == 1), 1'b0, b,
            (i % 2 == 0) && (i >= 2) && (i <= 34)};
      ec = 4'((k / 2) % 16);
      chk($sformatf("wrap[%0d]", i), eo, ec);
      if (i == 5)  bus.step = 1'b1;
      if (i == 6)  bus.step = 1'b0;
      if (i == 33) begin
        bus.run  = 1'b0;
        bus.step = 1'b1;
      end
      if (i == 34) bus.step = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
